// File: rtl/cpu_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, FSM state
// encoding and the instruction classes that select an execute sequence.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_T0     = 4'd1;
  localparam logic [3:0] S_T1     = 4'd2;
  localparam logic [3:0] S_T2     = 4'd3;
  localparam logic [3:0] S_T3     = 4'd4;
  localparam logic [3:0] S_T4     = 4'd5;
  localparam logic [3:0] S_T5     = 4'd6;
  localparam logic [3:0] S_T6     = 4'd7;
  localparam logic [3:0] S_HALTED = 4'd8;

  typedef enum logic [2:0] {
    RTYPE,
    IMM,
    MULDIV,
    UNARY,
    NOP,
    HALT
  } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Maps an opcode to the execute-sequence class; unknown opcodes run as nop.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t iclass
);

  always_comb begin
    iclass = NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:   iclass = RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:          iclass = IMM;
      OP_MUL, OP_DIV:                    iclass = MULDIV;
      OP_NEG, OP_NOT:                    iclass = UNARY;
      OP_HALT:                           iclass = HALT;
      default:                           iclass = NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control sequencer: fetch through T0-T2, then a per-class T3-T6 execute
// sequence. Outputs depend only on state, the first-T1 flag and the IR class.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic [31:0]    IR,
  input  logic           MemReady,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zhighout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           HIout,
  output logic           LOout,
  output logic           Cout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           HIin,
  output logic           LOin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           IncPC,
  output logic           Read,
  output logic [OPW-1:0] alu_op,
  output logic           Run,
  output logic [3:0]     state_dbg
);

  logic [3:0]   state;
  logic [3:0]   state_next;
  logic         t1_wait;
  logic [4:0]   opcode;
  instr_class_t iclass;
  logic [3:0]   done_next;
  logic         ir_unused;

  assign opcode    = IR[31:27];
  assign ir_unused = ^IR[26:0];
  assign state_dbg = state;

  instr_class_decode u_decode (
    .opcode (opcode),
    .iclass (iclass)
  );

  // Stop is only honoured on the last execute step of an instruction.
  assign done_next = Stop ? S_HALTED : S_T0;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1:   state_next = MemReady ? S_T2 : S_T1;
      S_T2:   state_next = S_T3;
      S_T3: begin
        case (iclass)
          NOP:     state_next = done_next;
          HALT:    state_next = S_HALTED;
          default: state_next = S_T4;
        endcase
      end
      S_T4:   state_next = (iclass == UNARY) ? done_next : S_T5;
      S_T5:   state_next = (iclass == MULDIV) ? S_T6 : done_next;
      S_T6:   state_next = done_next;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_IDLE;
      t1_wait <= 1'b0;
    end else begin
      state   <= state_next;
      t1_wait <= (state == S_T1) && !MemReady;
    end
  end

  // Gating on Resetn keeps every strobe low the instant reset asserts.
  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    alu_op = '0;
    Run = 1'b0;
    if (Resetn) begin
      Run = (state != S_IDLE) && (state != S_HALTED);
      case (state)
        S_T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        end
        S_T1: begin
          Zlowout = 1'b1; PCin = !t1_wait; Read = 1'b1; MDRin = 1'b1;
        end
        S_T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        S_T3: begin
          case (iclass)
            RTYPE, IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            MULDIV:     begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            UNARY: begin
              Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OPW'(opcode);
            end
            default: ;
          endcase
        end
        S_T4: begin
          case (iclass)
            RTYPE:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OPW'(opcode); end
            IMM:    begin Cout = 1'b1; Zin = 1'b1; alu_op = OPW'(opcode); end
            MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OPW'(opcode); end
            UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
        S_T5: begin
          case (iclass)
            RTYPE, IMM: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            MULDIV:     begin Zlowout = 1'b1; LOin = 1'b1; end
            default: ;
          endcase
        end
        S_T6: begin
          if (iclass == MULDIV) begin
            Zhighout = 1'b1; HIin = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-cycle expected schedule built from
// the instruction's micro-step list, driven with random IR/MemReady/Stop noise.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [31:0] IR;
  logic        MemReady;
  logic        Stop;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Run;
  logic [4:0] alu_op;
  logic [3:0] state_dbg;

  control_unit #(.OPW(5)) dut (
    .Clock(Clock), .Resetn(Resetn), .IR(IR), .MemReady(MemReady), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .IncPC(IncPC),
    .Read(Read), .alu_op(alu_op), .Run(Run), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  localparam logic [27:0] M_PCOUT    = 28'(1) << 27;
  localparam logic [27:0] M_ZHIGHOUT = 28'(1) << 26;
  localparam logic [27:0] M_ZLOWOUT  = 28'(1) << 25;
  localparam logic [27:0] M_MDROUT   = 28'(1) << 24;
  localparam logic [27:0] M_COUT     = 28'(1) << 21;
  localparam logic [27:0] M_MARIN    = 28'(1) << 20;
  localparam logic [27:0] M_ZIN      = 28'(1) << 19;
  localparam logic [27:0] M_PCIN     = 28'(1) << 18;
  localparam logic [27:0] M_MDRIN    = 28'(1) << 17;
  localparam logic [27:0] M_IRIN     = 28'(1) << 16;
  localparam logic [27:0] M_YIN      = 28'(1) << 15;
  localparam logic [27:0] M_HIIN     = 28'(1) << 14;
  localparam logic [27:0] M_LOIN     = 28'(1) << 13;
  localparam logic [27:0] M_GRA      = 28'(1) << 12;
  localparam logic [27:0] M_GRB      = 28'(1) << 11;
  localparam logic [27:0] M_GRC      = 28'(1) << 10;
  localparam logic [27:0] M_RIN      = 28'(1) << 9;
  localparam logic [27:0] M_ROUT     = 28'(1) << 8;
  localparam logic [27:0] M_INCPC    = 28'(1) << 7;
  localparam logic [27:0] M_READ     = 28'(1) << 6;
  localparam logic [27:0] M_RUN      = 28'(1) << 5;

  logic [27:0] obs;
  assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, MARin, Zin,
                PCin, MDRin, IRin, Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout,
                IncPC, Read, Run, alu_op};

  // scoreboard
  logic [27:0] exp_q[$];
  logic [31:0] ir_q[$];
  bit          mem_q[$];
  bit          stop_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [27:0] got, input logic [27:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%07h expected=%07h", tag, $time, got, exp);
    end
  endtask

  task automatic push_cycle(input logic [27:0] e, input logic [31:0] ir, input bit mem, input bit stp);
    exp_q.push_back(e);
    ir_q.push_back(ir);
    mem_q.push_back(mem);
    stop_q.push_back(stp);
  endtask

  // Reference model: fetch steps, then the micro-step list for the opcode.
  task automatic push_instr(input logic [31:0] ir, input int waits, input bit stop_final,
                            output bit halted);
    logic [27:0] steps[$];
    logic [27:0] alu;
    int op;
    bit is_halt;
    op = int'(ir[31:27]);
    alu = 28'(ir[31:27]);
    is_halt = (op == 27);
    push_cycle(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN, $urandom, 1'($urandom), 1'($urandom));
    for (int k = 0; k <= waits; k++)
      push_cycle(M_ZLOWOUT | M_READ | M_MDRIN | M_RUN | ((k == 0) ? M_PCIN : 28'(0)),
                 $urandom, (k == waits), 1'($urandom));
    push_cycle(M_MDROUT | M_IRIN | M_RUN, ir, 1'($urandom), 1'($urandom));
    if (op >= 3 && op <= 11) begin
      steps.push_back(M_GRB | M_ROUT | M_YIN);
      steps.push_back(M_GRC | M_ROUT | M_ZIN | alu);
      steps.push_back(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (op >= 12 && op <= 14) begin
      steps.push_back(M_GRB | M_ROUT | M_YIN);
      steps.push_back(M_COUT | M_ZIN | alu);
      steps.push_back(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (op == 15 || op == 16) begin
      steps.push_back(M_GRA | M_ROUT | M_YIN);
      steps.push_back(M_GRB | M_ROUT | M_ZIN | alu);
      steps.push_back(M_ZLOWOUT | M_LOIN);
      steps.push_back(M_ZHIGHOUT | M_HIIN);
    end else if (op == 17 || op == 18) begin
      steps.push_back(M_GRB | M_ROUT | M_ZIN | alu);
      steps.push_back(M_ZLOWOUT | M_GRA | M_RIN);
    end else begin
      steps.push_back(28'(0));
    end
    for (int i = 0; i < steps.size(); i++) begin
      bit last;
      last = (i == steps.size() - 1);
      push_cycle(steps[i] | M_RUN, ir, 1'($urandom),
                 (last && !is_halt) ? stop_final : 1'($urandom));
    end
    halted = is_halt || stop_final;
    if (halted)
      for (int i = 0; i < 3; i++) push_cycle(28'(0), $urandom, 1'b1, 1'b1);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) begin
      logic [27:0] e;
      @(negedge Clock);
      e = exp_q.pop_front();
      IR = ir_q.pop_front();
      MemReady = mem_q.pop_front();
      Stop = stop_q.pop_front();
      check_eq("ctrl", obs, e);
    end
  endtask

  task automatic run_all();
    run_n(exp_q.size());
  endtask

  task automatic clear_sched();
    exp_q.delete(); ir_q.delete(); mem_q.delete(); stop_q.delete();
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    MemReady = 1'b1;
    Stop = 1'b1;
    @(negedge Clock);
    check_eq("reset_idle", obs, 28'(0));
    @(negedge Clock);
    check_eq("reset_hold", obs, 28'(0));
    Stop = 1'b0;
    Resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    logic [4:0] ops [18];
    ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
            5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000,
            5'b10001, 5'b10010, 5'b11010, 5'b11011};
    Resetn = 1'b0;
    IR = '0;
    MemReady = 1'b0;
    Stop = 1'b0;
    do_reset();

    push_instr(32'h28918000, 0, 1'b0, h); run_all();   // and R1,R2,R3
    push_instr(32'h88080000, 0, 1'b0, h); run_all();   // neg R0,R1
    push_instr(32'h7B100000, 0, 1'b0, h); run_all();   // mul R6,R2
    push_instr(32'h18918000, 3, 1'b0, h); run_all();   // add with 3 wait cycles
    push_instr(32'h63000005, 1, 1'b0, h); run_all();   // addi
    push_instr(32'hD0000000, 0, 1'b0, h); run_all();   // nop
    push_instr(32'hF8000000, 0, 1'b0, h); run_all();   // illegal opcode
    push_instr(32'hD8000000, 0, 1'b0, h); run_all();   // halt
    do_reset();

    // Reset during T4 of an add must clear all strobes without a clock edge.
    push_instr(32'h18918000, 0, 1'b0, h);
    run_n(5);
    #1 Resetn = 1'b0;
    #1 check_eq("async_reset", obs, 28'(0));
    clear_sched();
    do_reset();
    push_instr(32'h18918000, 0, 1'b1, h); run_all();   // Stop on T5 -> HALTED
    do_reset();

    for (int n = 0; n < 80; n++) begin
      logic [31:0] ir;
      logic [4:0] op;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 16)];
      if ($urandom_range(0, 24) == 0) op = 5'b11011;
      ir = {op, 27'($urandom)};
      push_instr(ir, $urandom_range(0, 3), ($urandom_range(0, 11) == 0), h);
      run_all();
      if (h) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the 32-bit bus-based datapath. It replaces manually driven control strobes with a Moore state machine. The machine fetches each instruction through PC/MAR/MDR/IR and then runs the per-opcode T3–T6 execute steps, driving every bus-out, register-in, ALU-select and memory strobe. It sits beside `datapath` in the CPU top level and consumes only the IR contents and a memory-ready handshake.

## Interface
Parameters:
- `OPW`, 5, opcode / ALU-select width.

Ports:
- `Clock`  in  1  system clock, all state changes on rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `IR`  in  32  instruction register contents; opcode = IR[31:27].
- `MemReady`  in  1  memory read data valid on `Mdatain`.
- `Stop`  in  1  halt request, sampled only at instruction boundary.
- `PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout`  out  1 each  bus drivers; `Cout` drives the sign-extended IR[18:0].
- `MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin`  out  1 each  register load enables.
- `Gra, Grb, Grc, Rin, Rout`  out  1 each  register-file field select (IR[26:23], [22:19], [18:15]) and in/out strobes.
- `IncPC, Read`  out  1 each  PC increment and memory read.
- `alu_op`  out  `OPW`  ALU operation select.
- `Run`  out  1  high while executing; low in IDLE and HALTED.

## Operation
- Opcodes:
  - Three-register: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011.
  - Immediate: addi 01100, andi 01101, ori 01110.
  - mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011.
  - Any other opcode executes as nop.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED. Outputs are a pure function of state and the decoded class; every unlisted output is 0. `alu_op` = 00000 except in the ALU step, where it carries IR[31:27].
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin. The state holds in T1 with Read and MDRin asserted until MemReady=1. PCin pulses only on the first T1 cycle.
- T2: MDRout, IRin.
- Three-register ops (R-type):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op, Zin.
  - T5: Zlowout, Gra, Rin; then T0.
- Immediate ops: as R-type, except T4 uses Cout instead of Grc/Rout.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, alu_op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin; then T0.
- neg/not:
  - T3: Grb, Rout, alu_op, Zin.
  - T4: Zlowout, Gra, Rin; then T0.
- nop/illegal: T3 with no strobes, then T0.
- halt: T3 goes to HALTED. HALTED exits only via reset.
- Stop: sampled on the final execute step. If Stop=1, the next state is HALTED instead of T0. An instruction is never aborted mid-sequence.

## Timing
- While Resetn=0: state = IDLE and all outputs 0, including Run. The first rising edge after release moves IDLE→T0.
- Reset asserted in any state, including mid-T4/T5, forces IDLE combinationally. No partial write-back strobe may persist.
- IR is valid from T3 onward; decode uses IR only in T3–T6.
- Cycles per instruction with MemReady=1 in T1:
  - R-type and immediate: 6.
  - mul/div: 7.
  - neg/not: 5.
  - nop: 4.
  - Each MemReady=0 cycle in T1 adds one cycle.
- MemReady high outside T1 is ignored.

## Structure
- `cpu_pkg` holds the opcode constants, state encoding, and the instruction-class enum (RTYPE, IMM, MULDIV, UNARY, NOP, HALT).
- Sub-module `instr_class_decode` is a combinational mapping from IR[31:27] to the class. The FSM and output decode live in `control_unit`.

## Test plan
- IR=0x28918000 (and R1,R2,R3), MemReady=1:
  - State sequence T0..T5.
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=00101.
  - T5: Zlowout, Gra, Rin. Then T0.
- IR=0x88080000 (neg R0,R1):
  - T3: Grb, Rout, Zin, alu_op=10001.
  - T4: Zlowout, Gra, Rin.
  - 5 cycles total.
- IR=0x7B100000 (mul R6,R2):
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - 7 cycles total.
- MemReady held 0 for 3 cycles in T1:
  - Stays in T1 with Read=MDRin=1 for 4 cycles.
  - PCin asserted only on the first of them.
- IR=0xD8000000 (halt): enters HALTED, Run=0, all strobes 0. A later Stop/MemReady has no effect until Resetn pulses low.
- Resetn driven low during T4 of an add: all outputs 0 immediately. After release, IDLE→T0 on the next edge; Stop=1 during T5 of an add goes to HALTED.
